// File: rtl/sum_normalizer_if.sv
// Handshake bundle for sum_normalizer: adder result in, normalized mantissa out.
// The master side is the upstream/downstream environment; the slave side is the normalizer.
interface sum_normalizer_if;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] in_sum;
  logic        in_cout;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] out_mant;
  logic [3:0]  out_shift;
  logic        out_ovf;
  logic        out_zero;

  modport master (
    output in_valid, in_sum, in_cout, out_ready,
    input  in_ready, out_valid, out_mant, out_shift, out_ovf, out_zero
  );

  modport slave (
    input  in_valid, in_sum, in_cout, out_ready,
    output in_ready, out_valid, out_mant, out_shift, out_ovf, out_zero
  );
endinterface

// File: rtl/sum_normalizer.sv
// Left-normalizes a 13-bit adder sum (or right-shifts once on carry-out) with a
// three-state FSM. Define NORM_FASTSKIP_EN to skip four leading zeros per cycle.
module sum_normalizer (
  input  logic             clk,
  input  logic             rst,
  sum_normalizer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  logic [12:0] mant;
  logic [3:0]  shift;
  logic        ovf;
  logic        zero;

  // Only SHIFT is entered with a non-zero mant and bit 12 clear, so at most
  // 12 positions are ever added to shift and the 4-bit counter cannot wrap.
  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order within the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mant  <= '0;
      shift <= '0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            shift <= '0;
            ovf   <= bus.in_cout;
            zero  <= !bus.in_cout && (bus.in_sum == '0);
            if (bus.in_cout) begin
              mant  <= {1'b1, bus.in_sum[12:1]};
              state <= DONE;
            end else begin
              mant  <= bus.in_sum;
              state <= (bus.in_sum[12] || bus.in_sum == '0) ? DONE : SHIFT;
            end
          end
        end

        SHIFT: begin
`ifdef NORM_FASTSKIP_EN
          if (mant[12:9] == 4'b0000) begin
            mant  <= mant << 4;
            shift <= shift + 4'd4;
            if (mant[8]) state <= DONE;
          end else begin
            mant  <= mant << 1;
            shift <= shift + 4'd1;
            if (mant[11]) state <= DONE;
          end
`else
          mant  <= mant << 1;
          shift <= shift + 4'd1;
          if (mant[11]) state <= DONE;
`endif
        end

        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // in_ready drops with rst itself, not one edge later.
  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == DONE);
  assign bus.out_mant  = mant;
  assign bus.out_shift = shift;
  assign bus.out_ovf   = ovf;
  assign bus.out_zero  = zero;

endmodule
